controle_equilibrio: RTL and testbench

CONTROLE_EQUILIBRIO -- requirements
Module: controle_equilibrio

---
 rtl/controle_equilibrio.sv | 181 ++++++++++++++++++
 tb/tb_controle_equilibrio.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/controle_equilibrio.sv
// rtl/controle_equilibrio.sv - balance game controller: start/fall FSM, button and random drift steps, score
// A press or drift step moves the downstream counter; stepping past either end drops the game into CAIU.
module controle_equilibrio #(
    parameter int TICK_DIV    = 50000,
    parameter int SCORE_TICKS = 16,
    parameter int SCORE_N     = 8
) (
    input  logic               clock,
    input  logic               zera_n,
    input  logic               iniciar,
    input  logic               botao_esq,
    input  logic               botao_dir,
    input  logic               fim,
    input  logic               inicio,
    output logic               conta,
    output logic               count_up,
    output logic               zera_s,
    output logic [SCORE_N-1:0] score,
    output logic               jogando,
    output logic               caiu,
    output logic [1:0]         estado
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(SCORE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICKS_LAST = TW'(SCORE_TICKS - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        PREPARA = 2'b01,
        JOGANDO = 2'b10,
        CAIU    = 2'b11
    } estado_t;

    estado_t            state_q, state_d;
    logic               iniciar_prev_q, iniciar_prev_d;
    logic               esq_s1_q, esq_s1_d, esq_s2_q, esq_s2_d, esq_prev_q, esq_prev_d;
    logic               dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d, dir_prev_q, dir_prev_d;
    logic [PW-1:0]      prescaler_q, prescaler_d;
    logic [TW-1:0]      score_tick_q, score_tick_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               pend_press_q, pend_press_d, press_dir_q, press_dir_d;
    logic               pend_drift_q, pend_drift_d, drift_dir_q, drift_dir_d;
    logic [SCORE_N-1:0] score_q, score_d;
    logic               conta_q, conta_d, count_up_q, count_up_d, zera_s_q, zera_s_d;

    logic       press_esq, press_dir, drift_tick, issue_dir;
    logic [7:0] lfsr_next;

    assign press_esq  = esq_s2_q & ~esq_prev_q;
    assign press_dir  = dir_s2_q & ~dir_prev_q;
    assign drift_tick = (state_q == JOGANDO) && (prescaler_q == PRESC_LAST);
    // Fibonacci form of x^8+x^6+x^5+x^4+1
    assign lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d        = state_q;
        iniciar_prev_d = iniciar;
        esq_s1_d       = botao_esq;
        esq_s2_d       = esq_s1_q;
        esq_prev_d     = esq_s2_q;
        dir_s1_d       = botao_dir;
        dir_s2_d       = dir_s1_q;
        dir_prev_d     = dir_s2_q;
        prescaler_d    = prescaler_q;
        score_tick_d   = score_tick_q;
        lfsr_d         = lfsr_q;
        pend_press_d   = pend_press_q;
        press_dir_d    = press_dir_q;
        pend_drift_d   = pend_drift_q;
        drift_dir_d    = drift_dir_q;
        score_d        = score_q;
        conta_d        = 1'b0;
        count_up_d     = 1'b0;
        issue_dir      = 1'b0;

        case (state_q)
            OCIOSO, CAIU: begin
                if (iniciar && !iniciar_prev_q) state_d = PREPARA;
            end
            PREPARA: state_d = JOGANDO;
            JOGANDO: begin
                prescaler_d = drift_tick ? '0 : prescaler_q + PW'(1);
                // a cycle with conta low must separate consecutive steps
                if (!conta_q && (pend_press_q || pend_drift_q)) begin
                    issue_dir = pend_press_q ? press_dir_q : drift_dir_q;
                    if (pend_press_q) pend_press_d = 1'b0;
                    else              pend_drift_d = 1'b0;
                    if ((issue_dir && fim) || (!issue_dir && inicio)) begin
                        state_d = CAIU;
                    end else begin
                        conta_d    = 1'b1;
                        count_up_d = issue_dir;
                    end
                end
                if (drift_tick) begin
                    lfsr_d       = lfsr_next;
                    pend_drift_d = 1'b1;
                    drift_dir_d  = lfsr_next[0];
                    if (score_tick_q == TICKS_LAST) begin
                        score_tick_d = '0;
                        if (score_q != '1) score_d = score_q + SCORE_N'(1);
                    end else begin
                        score_tick_d = score_tick_q + TW'(1);
                    end
                end
                if (press_esq ^ press_dir) begin
                    pend_press_d = 1'b1;
                    press_dir_d  = press_dir;
                end
                if (state_d == CAIU) begin
                    pend_press_d = 1'b0;
                    pend_drift_d = 1'b0;
                end
            end
        endcase

        if (state_d == PREPARA) begin
            score_d      = '0;
            prescaler_d  = '0;
            score_tick_d = '0;
            pend_press_d = 1'b0;
            pend_drift_d = 1'b0;
        end
        zera_s_d = (state_d == OCIOSO) || (state_d == PREPARA);
    end

    always_ff @(posedge clock) begin
        if (!zera_n) begin
            state_q        <= OCIOSO;
            iniciar_prev_q <= 1'b0;
            esq_s1_q       <= 1'b0;
            esq_s2_q       <= 1'b0;
            esq_prev_q     <= 1'b0;
            dir_s1_q       <= 1'b0;
            dir_s2_q       <= 1'b0;
            dir_prev_q     <= 1'b0;
            prescaler_q    <= '0;
            score_tick_q   <= '0;
            lfsr_q         <= 8'hA5;
            pend_press_q   <= 1'b0;
            press_dir_q    <= 1'b0;
            pend_drift_q   <= 1'b0;
            drift_dir_q    <= 1'b0;
            score_q        <= '0;
            conta_q        <= 1'b0;
            count_up_q     <= 1'b0;
            zera_s_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            iniciar_prev_q <= iniciar_prev_d;
            esq_s1_q       <= esq_s1_d;
            esq_s2_q       <= esq_s2_d;
            esq_prev_q     <= esq_prev_d;
            dir_s1_q       <= dir_s1_d;
            dir_s2_q       <= dir_s2_d;
            dir_prev_q     <= dir_prev_d;
            prescaler_q    <= prescaler_d;
            score_tick_q   <= score_tick_d;
            lfsr_q         <= lfsr_d;
            pend_press_q   <= pend_press_d;
            press_dir_q    <= press_dir_d;
            pend_drift_q   <= pend_drift_d;
            drift_dir_q    <= drift_dir_d;
            score_q        <= score_d;
            conta_q        <= conta_d;
            count_up_q     <= count_up_d;
            zera_s_q       <= zera_s_d;
        end
    end

    assign conta    = conta_q;
    assign count_up = count_up_q;
    assign zera_s   = zera_s_q;
    assign score    = score_q;
    assign estado   = state_q;
    assign jogando  = (state_q == JOGANDO);
    assign caiu     = (state_q == CAIU);

endmodule

// File: tb/tb_controle_equilibrio.sv
// tb/tb_controle_equilibrio.sv - self-checking bench for controle_equilibrio
module tb_controle_equilibrio;

    localparam int TICK_DIV    = 4;
    localparam int SCORE_TICKS = 2;
    localparam int SCORE_N     = 8;
    localparam logic [1:0] ST_OCI = 2'b00, ST_PREP = 2'b01, ST_JOG = 2'b10, ST_CAIU = 2'b11;

    logic clock = 1'b0;
    logic zera_n = 1'b0, iniciar = 1'b0, botao_esq = 1'b0, botao_dir = 1'b0, fim = 1'b0, inicio = 1'b0;
    logic conta, count_up, zera_s, jogando, caiu;
    logic [SCORE_N-1:0] score;
    logic [1:0] estado;

    controle_equilibrio #(.TICK_DIV(TICK_DIV), .SCORE_TICKS(SCORE_TICKS), .SCORE_N(SCORE_N)) dut (
        .clock(clock), .zera_n(zera_n), .iniciar(iniciar), .botao_esq(botao_esq), .botao_dir(botao_dir),
        .fim(fim), .inicio(inicio), .conta(conta), .count_up(count_up), .zera_s(zera_s), .score(score),
        .jogando(jogando), .caiu(caiu), .estado(estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic cur_ini = 1'b0, cur_be = 1'b0, cur_bd = 1'b0, cur_f = 1'b0, cur_i = 1'b0;

    // Reference model: button history, play-cycle count and total drift ticks since start
    logic [1:0] m_state = ST_OCI;
    logic       m_iprev = 1'b0, m_conta = 1'b0, m_up = 1'b0;
    logic       e_hist [3];
    logic       d_hist [3];
    int         m_play = 0, m_ticks = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic       m_pp = 1'b0, m_pdir = 1'b0, m_pd = 1'b0, m_ddir = 1'b0;

    function automatic logic [SCORE_N-1:0] exp_score();
        int s;
        s = m_ticks / SCORE_TICKS;
        return (s > 255) ? 8'd255 : SCORE_N'(s);
    endfunction

    task automatic model_step(input logic rst, input logic ini, input logic be, input logic bd,
                              input logic f, input logic i);
        logic pe, pdv, tick, dir, nconta, nup;
        logic [1:0] nxt;
        if (!rst) begin
            m_state = ST_OCI; m_iprev = 0; m_conta = 0; m_up = 0; m_play = 0; m_ticks = 0;
            m_lfsr = 8'hA5; m_pp = 0; m_pd = 0; m_pdir = 0; m_ddir = 0;
            for (int k = 0; k < 3; k++) begin e_hist[k] = 0; d_hist[k] = 0; end
            return;
        end
        pe = e_hist[1] && !e_hist[2];
        pdv = d_hist[1] && !d_hist[2];
        nxt = m_state; nconta = 0; nup = 0;
        if (m_state == ST_OCI || m_state == ST_CAIU) begin
            if (ini && !m_iprev) nxt = ST_PREP;
        end else if (m_state == ST_PREP) begin
            nxt = ST_JOG;
        end else begin
            tick = (m_play % TICK_DIV) == TICK_DIV - 1;
            if (!m_conta && (m_pp || m_pd)) begin
                if (m_pp) begin dir = m_pdir; m_pp = 0; end
                else      begin dir = m_ddir; m_pd = 0; end
                if (dir ? f : i) nxt = ST_CAIU;
                else begin nconta = 1; nup = dir; end
            end
            if (tick) begin
                m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
                m_ticks++; m_pd = 1; m_ddir = m_lfsr[0];
            end
            if (pe != pdv) begin m_pp = 1; m_pdir = pdv; end
            m_play++;
            if (nxt == ST_CAIU) begin m_pp = 0; m_pd = 0; end
        end
        if (nxt == ST_PREP) begin m_play = 0; m_ticks = 0; m_pp = 0; m_pd = 0; end
        m_state = nxt; m_conta = nconta; m_up = nup; m_iprev = ini;
        e_hist[2] = e_hist[1]; e_hist[1] = e_hist[0]; e_hist[0] = be;
        d_hist[2] = d_hist[1]; d_hist[1] = d_hist[0]; d_hist[0] = bd;
    endtask

    task automatic cyc(input logic rst);
        @(negedge clock);
        zera_n = rst; iniciar = cur_ini; botao_esq = cur_be; botao_dir = cur_bd; fim = cur_f; inicio = cur_i;
        model_step(rst, cur_ini, cur_be, cur_bd, cur_f, cur_i);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        cur_ini = 1; cur_be = 1; cur_bd = 1;
        cyc(0);
        cur_be = 0; cur_bd = 0;
        cyc(0);
        checks++; if (estado !== ST_OCI) begin errors++; $display("FAIL reset_estado: got %b want %b", estado, ST_OCI); end
        checks++; if (conta !== 1'b0 || count_up !== 1'b0) begin errors++; $display("FAIL reset_conta: got %b/%b want 0/0", conta, count_up); end
        checks++; if (zera_s !== 1'b1) begin errors++; $display("FAIL reset_zera_s: got %b want 1", zera_s); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (jogando !== 1'b0 || caiu !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b want 0/0", jogando, caiu); end
        cur_ini = 0;
        cyc(1);
        checks++; if (estado !== ST_OCI) begin errors++; $display("FAIL idle_no_edge: got %b want %b", estado, ST_OCI); end
    endtask

    task automatic test_start();
        cur_ini = 1;
        cyc(1);
        checks++; if (estado !== ST_PREP || zera_s !== 1'b1) begin errors++; $display("FAIL start_prepara: got estado=%b zera_s=%b want 01/1", estado, zera_s); end
        cyc(1);
        checks++; if (estado !== ST_JOG || zera_s !== 1'b0 || jogando !== 1'b1) begin errors++; $display("FAIL start_jogando: got estado=%b zera_s=%b jogando=%b want 10/0/1", estado, zera_s, jogando); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL start_score: got %0d want 0", score); end
    endtask

    task automatic test_drift();
        logic exp_dir [4];
        int pulses;
        exp_dir[0] = 0; exp_dir[1] = 1; exp_dir[2] = 0; exp_dir[3] = 0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            checks++; if (conta !== m_conta) begin errors++; $display("FAIL drift_conta k=%0d: got %b want %b", k, conta, m_conta); end
            if (m_conta) begin
                checks++; if (count_up !== exp_dir[pulses % 4]) begin errors++; $display("FAIL drift_dir pulse=%0d: got %b want %b", pulses, count_up, exp_dir[pulses % 4]); end
                pulses++;
            end
            if (k == 8) begin
                checks++; if (score !== 8'd1) begin errors++; $display("FAIL drift_score8: got %0d want 1", score); end
            end
            if (k == 16) begin
                checks++; if (score !== 8'd2) begin errors++; $display("FAIL drift_score16: got %0d want 2", score); end
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL drift_pulse_count: got %0d want 4", pulses); end
    endtask

    task automatic test_collision();
        for (int k = 0; k < 8 && (m_play % TICK_DIV) != 1; k++) cyc(1);
        cur_bd = 1;
        cyc(1); cyc(1); cyc(1);
        cyc(1);
        checks++; if (conta !== 1'b1 || count_up !== 1'b1) begin errors++; $display("FAIL collide_press: got conta=%b up=%b want 1/1", conta, count_up); end
        cyc(1);
        checks++; if (conta !== 1'b0) begin errors++; $display("FAIL collide_guard: got %b want 0", conta); end
        cyc(1);
        checks++; if (conta !== 1'b1 || count_up !== m_up) begin errors++; $display("FAIL collide_drift: got conta=%b up=%b want 1/%b", conta, count_up, m_up); end
        cur_bd = 0;
        for (int k = 0; k < 4; k++) cyc(1);
    endtask

    task automatic test_cancel();
        int pulses;
        pulses = 0;
        cur_be = 1; cur_bd = 1;
        for (int k = 0; k < 16; k++) begin
            cyc(1);
            checks++; if (conta !== m_conta) begin errors++; $display("FAIL cancel_conta k=%0d: got %b want %b", k, conta, m_conta); end
            if (conta === 1'b1) pulses++;
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL cancel_pulses: got %0d want 4", pulses); end
        cur_be = 0; cur_bd = 0;
        for (int k = 0; k < 3; k++) cyc(1);
    endtask

    task automatic test_fall();
        int k;
        cur_f = 1; cur_bd = 1;
        for (k = 0; k < 20 && caiu !== 1'b1; k++) cyc(1);
        checks++; if (caiu !== 1'b1 || estado !== ST_CAIU || m_state !== ST_CAIU) begin errors++; $display("FAIL fall_reach: got caiu=%b estado=%b model=%b want 1/11/11", caiu, estado, m_state); end
        for (k = 0; k < 8; k++) begin
            cur_be = 1'($urandom); cur_bd = 1'($urandom);
            cyc(1);
            checks++; if (estado !== ST_CAIU || conta !== 1'b0 || score !== exp_score()) begin errors++; $display("FAIL fall_frozen: got estado=%b conta=%b score=%0d want 11/0/%0d", estado, conta, score, exp_score()); end
        end
        cur_be = 0; cur_bd = 0; cur_f = 0; cur_ini = 0;
        cyc(1);
        cur_ini = 1;
        cyc(1);
        checks++; if (estado !== ST_PREP || score !== 8'd0 || caiu !== 1'b0) begin errors++; $display("FAIL fall_restart: got estado=%b score=%0d caiu=%b want 01/0/0", estado, score, caiu); end
        cyc(1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(19) == 0) cur_ini = ~cur_ini;
            if ($urandom_range(7) == 0) cur_be = ~cur_be;
            if ($urandom_range(7) == 0) cur_bd = ~cur_bd;
            cur_f = ($urandom_range(9) == 0);
            cur_i = ($urandom_range(9) == 0);
            cyc(($urandom_range(399) == 0) ? 1'b0 : 1'b1);
            checks++;
            if (estado !== m_state || conta !== m_conta || (m_conta && count_up !== m_up) || score !== exp_score()
                || zera_s !== (m_state == ST_OCI || m_state == ST_PREP)
                || jogando !== (m_state == ST_JOG) || caiu !== (m_state == ST_CAIU)) begin
                errors++;
                $display("FAIL random k=%0d: got st=%b conta=%b up=%b score=%0d zs=%b want st=%b conta=%b up=%b score=%0d",
                         k, estado, conta, count_up, score, zera_s, m_state, m_conta, m_up, exp_score());
            end
        end
        cur_be = 0; cur_bd = 0; cur_f = 0; cur_i = 0;
    endtask

    task automatic test_saturate();
        int k;
        cur_ini = 0;
        cyc(0); cyc(1);
        cur_ini = 1;
        cyc(1); cyc(1);
        for (k = 0; k < 2100; k++) cyc(1);
        checks++; if (score !== 8'd255 || exp_score() !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d model %0d want 255", score, exp_score()); end
        for (k = 0; k < 16; k++) cyc(1);
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", score); end
        for (k = 0; k < 10 && conta !== 1'b1; k++) cyc(1);
        checks++; if (conta !== 1'b1) begin errors++; $display("FAIL sat_step_wait: got conta=%b want 1", conta); end
        cyc(0);
        checks++; if (conta !== 1'b0 || score !== 8'd0 || estado !== ST_OCI || zera_s !== 1'b1) begin errors++; $display("FAIL midstep_reset: got conta=%b score=%0d estado=%b zs=%b want 0/0/00/1", conta, score, estado, zera_s); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_drift();
        test_collision();
        test_cancel();
        test_fall();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
